// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - control codes, FSM state type and op classification for alu_mc.
package alu_mc_pkg;

  localparam logic [3:0] CTL_AND   = 4'b0000;
  localparam logic [3:0] CTL_OR    = 4'b0001;
  localparam logic [3:0] CTL_ADD   = 4'b0010;
  localparam logic [3:0] CTL_SLL   = 4'b0011;
  localparam logic [3:0] CTL_SRL   = 4'b0100;
  localparam logic [3:0] CTL_SRA   = 4'b0101;
  localparam logic [3:0] CTL_SUB   = 4'b0110;
  localparam logic [3:0] CTL_SLT   = 4'b0111;
  localparam logic [3:0] CTL_MUL   = 4'b1000;
  localparam logic [3:0] CTL_MULHU = 4'b1001;
  localparam logic [3:0] CTL_DIVU  = 4'b1010;
  localparam logic [3:0] CTL_REMU  = 4'b1011;
  localparam logic [3:0] CTL_NOR   = 4'b1100;
  localparam logic [3:0] CTL_XOR   = 4'b1101;
  localparam logic [3:0] CTL_SLTU  = 4'b1110;
  localparam logic [3:0] CTL_RSVD  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  // Codes 10xx go to the iterative engine; bit 1 selects divide over multiply.
  function automatic logic is_multicycle(input logic [3:0] c);
    return c[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - iterative shift-add multiplier / restoring divider, one bit per cycle.
module alu_seq_muldiv
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_d;
  logic [WIDTH-1:0] mul_lo_d;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_r_d;
  logic [WIDTH-1:0] div_q_d;

  // hi_q/lo_q hold {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_d  = mul_sum[WIDTH:1];
    mul_lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_r_d   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_q_d   = {lo_q[WIDTH-2:0], div_ge};
  end

  assign done_o      = busy_q && (cnt_q == LAST);
  assign hi_o        = mul_hi_d;
  assign lo_o        = mul_lo_d;
  assign quotient_o  = div_q_d;
  assign remainder_o = div_r_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      div_q  <= op_i;
      cnt_q  <= '0;
      opnd_q <= op_i ? b_i : a_i;
      hi_q   <= '0;
      lo_q   <= op_i ? a_i : b_i;
    end else if (busy_q) begin
      hi_q  <= div_q ? div_r_d : mul_hi_d;
      lo_q  <= div_q ? div_q_d : mul_lo_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: single-cycle ops inline, mul/div via iterative engine, valid/ready handshake.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             oflow
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_e           state_q;
  logic [3:0]       ctl_q;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             oflow_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ov;
  logic             sub_ov;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ov;
  logic [WIDTH-1:0] md_res;

  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_quo;
  logic [WIDTH-1:0] md_rem;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign zero      = zero_q;
  assign oflow     = oflow_q;

  assign md_start = in_valid && (state_q == S_IDLE) && is_multicycle(ctl);

  always_comb begin
    sum     = a + b;
    diff    = a - b;
    add_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sub_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    shamt   = b[SHAMT_W-1:0];
    alu_res = '0;
    alu_ov  = 1'b0;
    case (ctl)
      CTL_ADD: begin alu_res = sum;  alu_ov = add_ov; end
      CTL_SUB: begin alu_res = diff; alu_ov = sub_ov; end
      CTL_AND:  alu_res = a & b;
      CTL_OR:   alu_res = a | b;
      CTL_NOR:  alu_res = ~(a | b);
      CTL_XOR:  alu_res = a ^ b;
      CTL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ov};
      CTL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      CTL_SLL:  alu_res = a << shamt;
      CTL_SRL:  alu_res = a >> shamt;
      CTL_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    case (ctl_q)
      CTL_MUL:   md_res = md_lo;
      CTL_MULHU: md_res = md_hi;
      CTL_DIVU:  md_res = md_quo;
      default:   md_res = md_rem;
    endcase
  end

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk         (clk),
    .rst         (rst),
    .start_i     (md_start),
    .op_i        (ctl[1]),
    .a_i         (a),
    .b_i         (b),
    .done_o      (md_done),
    .hi_o        (md_hi),
    .lo_o        (md_lo),
    .quotient_o  (md_quo),
    .remainder_o (md_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctl_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      oflow_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          ctl_q <= ctl;
          if (is_multicycle(ctl)) begin
            state_q <= ctl[1] ? S_DIV : S_MUL;
          end else begin
            out_q   <= alu_res;
            zero_q  <= (alu_res == '0);
            oflow_q <= alu_ov;
            state_q <= S_DONE;
          end
        end
        S_MUL, S_DIV: if (md_done) begin
          out_q   <= md_res;
          zero_q  <= (md_res == '0);
          oflow_q <= 1'b0;
          state_q <= S_DONE;
        end
        default: if (out_ready) state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU; next generation of the single-cycle datapath ALU.
- Keeps the existing 4-bit control encoding.
- Adds shifts right, unsigned compare, iterative multiply and divide, add/sub overflow flag, and a valid/ready handshake.
- Sits in the execute stage. The pipeline stalls on in_ready/out_valid; a single operation is in flight at any time.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHAMT_W, $clog2(WIDTH), number of low b bits used as shift amount (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ctl/a/b valid this cycle.
- in_ready  output  1  high only in IDLE; operation accepted when in_valid && in_ready.
- ctl  input  4  operation code (see Behaviour).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result/flags valid; held until out_ready.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  result.
- zero  output  1  out == 0.
- oflow  output  1  signed overflow; add/sub only, else 0.

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE; out, zero, oflow, out_valid all 0; in_ready 1 on the following cycle.
  - Any in-flight operation is discarded, including one in MUL, DIV or DONE.
- Operand capture: ctl/a/b are registered at acceptance. Input changes while busy are ignored.
- Codes unchanged from the current ALU:
  - 0010 add; 0110 sub; 0000 and; 0001 or; 1100 nor; 1101 xor.
  - 0111 slt (signed); 0011 sll.
- New codes:
  - 0100 srl; 0101 sra; 1110 sltu.
  - 1000 mul (low WIDTH bits of the product).
  - 1001 mulhu (high WIDTH bits of the unsigned product).
  - 1010 divu; 1011 remu.
  - 1111 reserved: out = 0.
- Shifts use b[SHAMT_W-1:0] only.
- slt: compare a - b with overflow correction. sltu: unsigned compare. Both zero-extend to WIDTH.
- oflow:
  - add: operand signs equal and result sign differs.
  - sub: operand signs differ and result sign differs from a.
- Divide by zero: divu gives all ones; remu gives a. Latency is unchanged.
- States:
  - IDLE: in_ready = 1. On accept:
    - single-cycle code: compute, register result, go to DONE.
    - 1000/1001: go to MUL.
    - 1010/1011: go to DIV.
  - MUL: shift-add, one bit per cycle, WIDTH cycles, then load result and go to DONE.
  - DIV: restoring divide, one quotient bit per cycle, WIDTH cycles, then go to DONE.
  - DONE: out_valid = 1; out/zero/oflow stable. When out_ready is high, go to IDLE and drop out_valid the next cycle.
- No accept is allowed in DONE, so single-cycle ops run at 1 op per 2 cycles minimum.
- Latency from the accept edge to out_valid high:
  - single-cycle ops: 1 cycle.
  - mul/mulhu/divu/remu: WIDTH+1 cycles.
- If out_ready is already high when out_valid rises, the result is visible for exactly one cycle.
- zero and oflow are registered together with out and change only on entry to DONE or on reset.

Decomposition:
- Package alu_mc_pkg:
  - localparams for all 4-bit ctl codes, including the legacy ones.
  - state enum {IDLE, MUL, DIV, DONE}.
  - function is_multicycle(ctl).
- Sub-module alu_seq_muldiv:
  - iterative mul/div engine (start, op, a, b → done, hi, lo, quotient, remainder).
  - bit counter width $clog2(WIDTH)+1.
  - alu_mc keeps the combinational single-cycle ops and the handshake FSM.

Test Plan (WIDTH=32):
- Add overflow: add a=0x7FFFFFFF, b=1, out_ready=1 → out_valid 1 cycle after accept; out=0x80000000, oflow=1, zero=0. Then sub a=5, b=5 → out=0, zero=1, oflow=0.
- Shifts: sra a=0x80000000, b=0x24 → shamt 4, out=0xF8000000. Then srl with the same operands → 0x08000000. Then sll a=1, b=31 → 0x80000000.
- Compares: slt a=0xFFFFFFFF, b=1 → 1. Then sltu with the same operands → 0. Then code 1111 → out=0, zero=1.
- Multiply: mul a=0xFFFFFFFF, b=2 → out_valid exactly 33 cycles after accept, out=0xFFFFFFFE. Then mulhu with the same operands → 0x00000001. in_ready stays 0 throughout, and toggling a/b mid-op has no effect.
- Divide: divu a=100, b=7 → 14; remu → 2. divu a=9, b=0 → 0xFFFFFFFF; remu → 9. Hold out_ready=0 for 5 cycles → out_valid and out stable; accept occurs only after out_ready.
- Reset mid-op: assert rst 10 cycles into a divu → next cycle out_valid=0, out=0, in_ready=1. A new add a=2, b=3 then completes with out=5.
